// File: rtl/irq_pending_collector.sv
// Request synchroniser, rising-edge capture into sticky pending bits, and masked
// highest-index selection on a valid/ready handshake. Optional overflow flags: IRQ_OVERFLOW_EN.
module irq_pending_collector #(
    parameter int NUM_SRC     = 4,
    parameter int IDX_W       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req_in,
    input  logic [NUM_SRC-1:0] mask_in,
    input  logic               irq_ready,
`ifdef IRQ_OVERFLOW_EN
    input  logic [NUM_SRC-1:0] ovf_clr,
    output logic [NUM_SRC-1:0] ovf_out,
`endif
    output logic               irq_valid,
    output logic [IDX_W-1:0]   irq_idx,
    output logic [NUM_SRC-1:0] pending_out
);

    typedef enum logic {IDLE, PRESENT} state_t;

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] hist_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] event_w, clr_w, elig_w;
    logic [IDX_W-1:0]   sel_idx_w;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               accept_w;
    state_t             state_q, state_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            hist_q <= '0;
        end else begin
            sync_q[0] <= req_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign event_w  = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign accept_w = valid_q & irq_ready;
    assign elig_w   = pending_q & mask_in;

    always_comb begin
        clr_w = '0;
        if (accept_w) clr_w[idx_q] = 1'b1;
    end

    // A new event on the bit being accepted re-arms it: set beats clear.
    assign pending_d = (pending_q & ~clr_w) | event_w;

    always_comb begin
        sel_idx_w = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig_w[i]) sel_idx_w = IDX_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (elig_w != '0) begin
                    idx_d   = sel_idx_w;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // Held until accepted; later arrivals and mask changes cannot preempt.
                if (irq_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

`ifdef IRQ_OVERFLOW_EN
    logic [NUM_SRC-1:0] ovf_q, ovf_d;

    assign ovf_d = (ovf_q & ~ovf_clr) | (event_w & pending_q & ~clr_w);

    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= '0;
        else        ovf_q <= ovf_d;
    end

    assign ovf_out = ovf_q;
`endif

    assign irq_valid   = valid_q;
    assign irq_idx     = idx_q;
    assign pending_out = pending_q;

endmodule

// File: tb/tb_irq_pending_collector.sv
// Directed and randomized bench for irq_pending_collector with a cycle-level reference model
// built on a history queue of sampled request values.
module tb_irq_pending_collector;

    localparam int N = 4;
    localparam int W = 2;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_in, mask_in;
    logic         irq_ready;
    logic         irq_valid;
    logic [W-1:0] irq_idx;
    logic [N-1:0] pending_out;
`ifdef IRQ_OVERFLOW_EN
    logic [N-1:0] ovf_clr, ovf_out;
`endif

    always #5 clk = ~clk;

    irq_pending_collector #(.NUM_SRC(N), .IDX_W(W), .SYNC_STAGES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_in     (req_in),
        .mask_in    (mask_in),
        .irq_ready  (irq_ready),
`ifdef IRQ_OVERFLOW_EN
        .ovf_clr    (ovf_clr),
        .ovf_out    (ovf_out),
`endif
        .irq_valid  (irq_valid),
        .irq_idx    (irq_idx),
        .pending_out(pending_out)
    );

    int compared   = 0;
    int mismatched = 0;

    // smp[0] is the most recently sampled req_in; entries hold S+1 edges of history.
    logic [N-1:0] smp[$];
    logic [N-1:0] m_pend;
    logic [W-1:0] m_idx;
    logic         m_valid;
    logic [N-1:0] m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] ev, clr, elig, nxt;
        if (!rst_n) begin
            foreach (smp[j]) smp[j] = '0;
            m_pend = '0; m_valid = 1'b0; m_idx = '0; m_ovf = '0;
            return;
        end
        ev  = smp[S-1] & ~smp[S];
        clr = '0;
        if (m_valid && irq_ready) clr[m_idx] = 1'b1;
`ifdef IRQ_OVERFLOW_EN
        m_ovf = (m_ovf & ~ovf_clr) | (ev & m_pend & ~clr);
`endif
        nxt = (m_pend & ~clr) | ev;
        if (m_valid) begin
            if (irq_ready) m_valid = 1'b0;
        end else begin
            elig = m_pend & mask_in;
            if (elig != '0) begin
                for (int i = 0; i < N; i++) if (elig[i]) m_idx = W'(i);
                m_valid = 1'b1;
            end
        end
        m_pend = nxt;
        smp.push_front(req_in);
        void'(smp.pop_back());
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("model_valid", 32'(irq_valid), 32'(m_valid));
        chk("model_idx", 32'(irq_idx), 32'(m_idx));
        chk("model_pending", 32'(pending_out), 32'(m_pend));
`ifdef IRQ_OVERFLOW_EN
        chk("model_ovf", 32'(ovf_out), 32'(m_ovf));
`endif
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    initial begin
        for (int j = 0; j <= S; j++) smp.push_back('0);
        m_pend = '0; m_valid = 1'b0; m_idx = '0; m_ovf = '0;
        rst_n = 1'b0; req_in = '0; mask_in = 4'hF; irq_ready = 1'b0;
`ifdef IRQ_OVERFLOW_EN
        ovf_clr = '0;
`endif
        #1;
        steps(2);
        chk("reset_valid", 32'(irq_valid), 32'd0);
        chk("reset_idx", 32'(irq_idx), 32'd0);
        chk("reset_pending", 32'(pending_out), 32'd0);

        // Single source latency and hold
        rst_n = 1'b1; req_in = 4'b0010;
        step(); chk("t1_pend_k", 32'(pending_out), 32'd0);
        step(); chk("t1_pend_k1", 32'(pending_out), 32'd0);
        step(); chk("t1_pend_k2", 32'(pending_out), 32'b0010);
        chk("t1_valid_k2", 32'(irq_valid), 32'd0);
        req_in = '0;
        step(); chk("t1_valid_k3", 32'(irq_valid), 32'd1);
        chk("t1_idx_k3", 32'(irq_idx), 32'd1);
        steps(3); chk("t1_hold", 32'(irq_valid), 32'd1);
        irq_ready = 1'b1;
        step(); chk("t1_accept_valid", 32'(irq_valid), 32'd0);
        chk("t1_accept_pend", 32'(pending_out), 32'd0);

        // Two simultaneous sources, back-to-back grants with one bubble
        req_in = 4'b1001;
        steps(3); chk("t2_pend", 32'(pending_out), 32'b1001);
        step();   chk("t2_idx3", 32'(irq_idx), 32'd3);
        chk("t2_valid3", 32'(irq_valid), 32'd1);
        step();   chk("t2_bubble", 32'(irq_valid), 32'd0);
        step();   chk("t2_idx0", 32'(irq_idx), 32'd0);
        chk("t2_valid0", 32'(irq_valid), 32'd1);
        step();   chk("t2_pend_end", 32'(pending_out), 32'd0);
        req_in = '0; irq_ready = 1'b0;
        steps(2);

        // No preemption by a later higher-priority arrival
        req_in = 4'b0010;
        steps(4);
        req_in = 4'b1010;
        steps(5); chk("t3_idx_held", 32'(irq_idx), 32'd1);
        chk("t3_pend", 32'(pending_out), 32'b1010);
        irq_ready = 1'b1;
        step(); irq_ready = 1'b0;
        step(); chk("t3_next_idx", 32'(irq_idx), 32'd3);
        chk("t3_next_valid", 32'(irq_valid), 32'd1);
        irq_ready = 1'b1;
        step(); irq_ready = 1'b0; req_in = '0;
        steps(3);

        // Masked pending retained, then granted after unmask
        mask_in = 4'b0111; req_in = 4'b1000;
        steps(5); chk("t4_masked_valid", 32'(irq_valid), 32'd0);
        chk("t4_masked_pend", 32'(pending_out), 32'b1000);
        mask_in = 4'hF;
        step(); chk("t4_unmask_idx", 32'(irq_idx), 32'd3);
        chk("t4_unmask_valid", 32'(irq_valid), 32'd1);
        irq_ready = 1'b1;
        step(); irq_ready = 1'b0; req_in = '0;
        steps(2);

        // Event coinciding with acceptance of the same index
        req_in = 4'b0100;
        steps(4);
        req_in = '0;
        steps(3);
        req_in = 4'b0100;
        steps(2);
        irq_ready = 1'b1;
        step(); chk("t5_pend_kept", 32'(pending_out), 32'b0100);
        chk("t5_valid_drop", 32'(irq_valid), 32'd0);
        irq_ready = 1'b0;
        step(); chk("t5_regrant_idx", 32'(irq_idx), 32'd2);
        chk("t5_regrant_valid", 32'(irq_valid), 32'd1);
        irq_ready = 1'b1;
        step(); irq_ready = 1'b0; req_in = '0;
        steps(2);

        // Reset mid-handshake, with lines held high through release
        req_in = 4'b1010;
        steps(5); chk("t6_pre_valid", 32'(irq_valid), 32'd1);
        chk("t6_pre_pend", 32'(pending_out), 32'b1010);
        rst_n = 1'b0;
        step(); chk("t6_rst_valid", 32'(irq_valid), 32'd0);
        chk("t6_rst_pend", 32'(pending_out), 32'd0);
        rst_n = 1'b1;
        steps(6);
        irq_ready = 1'b1;
        steps(4);
        irq_ready = 1'b0; req_in = '0;
        steps(3);

`ifdef IRQ_OVERFLOW_EN
        mask_in = '0; req_in = 4'b0001;
        steps(3);
        req_in = '0;
        steps(2);
        req_in = 4'b0001;
        steps(3); chk("ovf_set", 32'(ovf_out[0]), 32'd1);
        ovf_clr = 4'b0001;
        step(); ovf_clr = '0;
        chk("ovf_clr", 32'(ovf_out[0]), 32'd0);
        mask_in = 4'hF; req_in = '0; irq_ready = 1'b1;
        steps(4);
        irq_ready = 1'b0;
`endif

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            rst_n     = ($urandom_range(0, 79) != 0);
            req_in    = req_in ^ N'($urandom & $urandom & 32'hF);
            mask_in   = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'hF;
            irq_ready = ($urandom_range(0, 2) == 0);
`ifdef IRQ_OVERFLOW_EN
            ovf_clr   = N'($urandom & $urandom & $urandom);
`endif
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/irq_pending_collector.md
Name: irq_pending_collector

Overview:
Upstream stage of the 4-input priority encoder. It synchronises asynchronous request lines and turns rising edges into sticky pending bits. It masks them, selects the highest-priority enabled pending source (bit NUM_SRC-1 highest, same ordering as the encoder), and presents its index on a valid/ready handshake. The consumer's acceptance clears that source's pending bit.

Parameters:
NUM_SRC, 4, number of request sources
IDX_W, 2, width of irq_idx; must equal clog2(NUM_SRC)
SYNC_STAGES, 2, synchroniser flops per request line (legal values 1..3)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
req_in  input  NUM_SRC  asynchronous request lines; a rising edge creates an event
mask_in  input  NUM_SRC  1 = source enabled for selection
irq_ready  input  1  consumer accepts the presented index
irq_valid  output  1  index presented
irq_idx  output  IDX_W  index of the selected source
pending_out  output  NUM_SRC  raw pending bits, unmasked

Behaviour:
- Reset (rst_n low at a clk edge):
  - synchroniser flops, edge-detect history, pending, irq_valid, irq_idx and FSM state all become 0 / IDLE.
  - Outputs read 0 from the edge after rst_n is sampled low.
- Synchroniser and edge detect:
  - req_in[i] passes through SYNC_STAGES flops; a history flop holds the previous synchronised value.
  - Event = synchronised value 1 while history is 0.
  - A line held high through reset release produces exactly one event.
- Pending bits:
  - Bit i is set on an event and cleared on acceptance of index i.
  - Event and clear for the same bit in the same cycle: set wins, and the bit stays 1.
- Latency (SYNC_STAGES=2): if k is the first clk edge sampling req_in[i]=1, pending_out[i] rises after edge k+2 and irq_valid can rise after edge k+3.
- Masking:
  - A masked pending bit is retained but not selectable.
  - Unmasking a retained pending bit makes it eligible on the next IDLE evaluation.
- Selection: among pending & mask_in, the highest index wins.
- FSM IDLE:
  - If (pending & mask_in) != 0, register the selected index into irq_idx, set irq_valid=1 and go to PRESENT.
  - Otherwise stay in IDLE with irq_valid=0.
- FSM PRESENT:
  - irq_idx and irq_valid are held stable until irq_valid & irq_ready at a clk edge.
  - No preemption by higher-priority arrivals. Mask changes do not withdraw the presented index.
  - On acceptance: clear pending[irq_idx], set irq_valid=0 and go to IDLE. This gives one bubble cycle between back-to-back grants.
- irq_idx is registered and holds its last value while irq_valid=0.
- irq_ready while irq_valid=0 is ignored.
- Reset mid-handshake drops irq_valid and discards all pending events.

Optional Feature:
Macro IRQ_OVERFLOW_EN.
- Defined:
  - Adds input ovf_clr [NUM_SRC] and output ovf_out [NUM_SRC].
  - ovf_out[i] is a sticky flag. It sets when an event on i arrives while pending[i]=1 and pending[i] is not being cleared that cycle.
  - ovf_clr[i] clears it on the next edge. Set wins over clear.
  - ovf_out resets to 0.
- Undefined: these ports and flops are absent; lost events are silently merged.

Test Plan:
1. Reset, then pulse req_in=4'b0010 for 3 cycles with mask_in=4'hF and irq_ready=0 -> pending_out=4'b0010 at k+2; irq_valid=1 and irq_idx=1 at k+3, held until irq_ready.
2. Raise req_in bits 0 and 3 on the same edge, irq_ready=1 -> grants irq_idx=3 then irq_idx=0, with exactly one irq_valid=0 cycle between them; pending_out ends 4'b0000.
3. Present idx=1 with irq_ready=0, then raise req_in[3] -> irq_idx stays 1 until accepted; next grant is idx=3.
4. mask_in=4'b0111 with an event on bit 3 -> irq_valid stays 0 and pending_out[3]=1; set mask_in=4'hF -> irq_idx=3 granted.
5. Event on bit 2 timed to coincide with acceptance of idx=2 -> pending_out[2] remains 1 and a second grant of idx=2 follows.
6. Drive rst_n=0 for one edge while irq_valid=1 with pending 4'b1010 -> next cycle irq_valid=0 and pending_out=0.
   - With IRQ_OVERFLOW_EN: two events on bit 0 with no acceptance in between -> ovf_out[0]=1; pulse ovf_clr[0] -> ovf_out[0]=0.
